// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: produces latch enable and flush strobes.
// Define PIPE_CTRL_PERF_EN to build the stall and flush performance counters.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_req,
    input  logic        branch_taken,
    input  logic        load_use,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   halt_q;

    // Strobes and next state; a pending data miss freezes every stage and bubbles MEM/WB.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_d     = RUN;
        end else begin
            case (state_q)
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    if (state_q == DWAIT && !dhit) begin
                        memwb_flush = 1'b1;
                    end else if (wb_halt) begin
                        state_d = HALTED;
                    end else if (state_q == RUN && mem_req && !dhit) begin
                        memwb_flush = 1'b1;
                        state_d     = DWAIT;
                    end else begin
                        state_d  = RUN;
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (branch_taken) begin
                            ifid_en    = 1'b0;
                            idex_en    = 1'b0;
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_en    = 1'b0;
                            idex_flush = 1'b1;
                        end else if (!ihit) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
        end
    end

    assign halt = halt_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;

    // Only the taken-branch case advances the PC while flushing IF/ID.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (state_q != HALTED && !pc_en && stallCnt_q != 32'hFFFF_FFFF) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
        if (pc_en && ifid_flush && flushCnt_q != 32'hFFFF_FFFF) begin
            flushCnt_d = flushCnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stallCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl; counter checks adapt to PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Strobe vector: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [8:0] ALL_EN = 9'b1_1111_0000;
    localparam logic [8:0] RST_V  = 9'b0_0000_1111;
    localparam logic [8:0] NONE   = 9'b0_0000_0000;
    localparam logic [8:0] RULE_B = 9'b0_0000_0001;
    localparam logic [8:0] RULE_C = 9'b1_0011_1100;
    localparam logic [8:0] RULE_D = 9'b0_0011_0100;
    localparam logic [8:0] RULE_E = 9'b0_0111_1000;

    logic        clock = 1'b0;
    logic        reset, ihit, dhit, memReq, branchTaken, loadUse, wbHalt;
    logic        pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic        ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic        halt;
    logic [31:0] stallCnt, flushCnt;

    logic [8:0]  expQ[$];
    int          assertCount = 0;
    int          failCount   = 0;

    pipeline_ctrl dut (
        .CLK          (clock),
        .RST          (reset),
        .ihit         (ihit),
        .dhit         (dhit),
        .mem_req      (memReq),
        .branch_taken (branchTaken),
        .load_use     (loadUse),
        .wb_halt      (wbHalt),
        .pc_en        (pcEn),
        .ifid_en      (ifidEn),
        .idex_en      (idexEn),
        .exmem_en     (exmemEn),
        .memwb_en     (memwbEn),
        .ifid_flush   (ifidFlush),
        .idex_flush   (idexFlush),
        .exmem_flush  (exmemFlush),
        .memwb_flush  (memwbFlush),
        .halt         (halt),
        .stall_cnt    (stallCnt),
        .flush_cnt    (flushCnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and record the strobes they should produce.
    task automatic applyStimulus(input logic rstV, input logic ihitV, input logic dhitV,
                                 input logic memReqV, input logic branchV, input logic loadUseV,
                                 input logic wbHaltV, input logic [8:0] exp);
        @(negedge clock);
        reset       = rstV;
        ihit        = ihitV;
        dhit        = dhitV;
        memReq      = memReqV;
        branchTaken = branchV;
        loadUse     = loadUseV;
        wbHalt      = wbHaltV;
        expQ.push_back(exp);
    endtask

    task automatic checkOutput(input string tag);
        logic [8:0] exp;
        #1;
        if (expQ.size() == 0) begin
            compare({tag, " (empty scoreboard)"}, 32'd0, 32'd1);
        end else begin
            exp = expQ.pop_front();
            compare(tag, {23'd0, pcEn, ifidEn, idexEn, exmemEn, memwbEn,
                          ifidFlush, idexFlush, exmemFlush, memwbFlush}, {23'd0, exp});
        end
    endtask

    task automatic step(input logic rstV, input logic ihitV, input logic dhitV,
                        input logic memReqV, input logic branchV, input logic loadUseV,
                        input logic wbHaltV, input logic [8:0] exp, input string tag);
        applyStimulus(rstV, ihitV, dhitV, memReqV, branchV, loadUseV, wbHaltV, exp);
        checkOutput(tag);
    endtask

    task automatic afterEdge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; ihit = 1'b0; dhit = 1'b0; memReq = 1'b0;
        branchTaken = 1'b0; loadUse = 1'b0; wbHalt = 1'b0;

        // Reset held two cycles with noisy inputs, then release.
        step(1, 1, 0, 1, 1, 1, 1, RST_V, "reset cycle 1");
        step(1, 0, 1, 0, 0, 1, 0, RST_V, "reset cycle 2");
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "run after reset");
        afterEdge();
        compare("halt after reset", {31'd0, halt}, 32'd0);
        compare("stall_cnt after reset", stallCnt, 32'd0);
        compare("flush_cnt after reset", flushCnt, 32'd0);

        // Data miss for three cycles, then the access completes.
        step(0, 1, 0, 1, 0, 0, 0, RULE_B, "dmiss cycle 1");
        step(0, 1, 0, 1, 0, 0, 0, RULE_B, "dwait cycle 2");
        step(0, 1, 0, 1, 0, 0, 0, RULE_B, "dwait cycle 3");
        step(0, 1, 1, 1, 0, 0, 0, ALL_EN, "dwait dhit");
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "back in run");
        afterEdge();
        compare("stall_cnt after miss", stallCnt, PERF ? 32'd3 : 32'd0);

        // Branch outranks load-use and a missing fetch.
        step(0, 0, 0, 0, 1, 1, 0, RULE_C, "branch priority");
        afterEdge();
        compare("flush_cnt after branch", flushCnt, PERF ? 32'd1 : 32'd0);

        step(0, 1, 0, 0, 0, 1, 0, RULE_D, "load use");
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "after load use");
        step(0, 0, 0, 0, 0, 0, 0, RULE_E, "ifetch miss");
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "after ifetch miss");
        afterEdge();
        compare("stall_cnt after hazards", stallCnt, PERF ? 32'd5 : 32'd0);

        // Halt from WB is sticky regardless of later inputs.
        step(0, 1, 1, 0, 0, 0, 1, NONE, "wb halt");
        afterEdge();
        compare("halt set", {31'd0, halt}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], ~i[0], i[1], i[0], 1'b0, 1'b0, NONE, "halted strobes");
        end
        afterEdge();
        compare("halt sticky", {31'd0, halt}, 32'd1);
        compare("stall_cnt held in halt", stallCnt, PERF ? 32'd6 : 32'd0);
        compare("flush_cnt held in halt", flushCnt, PERF ? 32'd1 : 32'd0);

        step(1, 1, 1, 0, 0, 0, 0, RST_V, "reset from halt");
        afterEdge();
        compare("halt cleared", {31'd0, halt}, 32'd0);
        compare("stall_cnt cleared", stallCnt, 32'd0);

        // Reset taken in the middle of a data wait.
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "run after halt reset");
        step(0, 1, 0, 1, 0, 0, 0, RULE_B, "dmiss before reset");
        step(1, 1, 0, 1, 0, 0, 0, RST_V, "reset in dwait");
        step(0, 1, 0, 0, 0, 0, 0, ALL_EN, "run after dwait reset");
        afterEdge();
        compare("stall_cnt after dwait reset", stallCnt, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        @(negedge clock);
        dut.stallCnt_q = 32'hFFFF_FFFE;
        dut.flushCnt_q = 32'hFFFF_FFFF;
`endif
        step(0, 0, 0, 0, 0, 0, 0, RULE_E, "sat stall 1");
        step(0, 0, 0, 0, 0, 0, 0, RULE_E, "sat stall 2");
        step(0, 0, 0, 0, 0, 0, 0, RULE_E, "sat stall 3");
        step(0, 1, 0, 0, 1, 0, 0, RULE_C, "sat branch");
        afterEdge();
        compare("stall_cnt saturated", stallCnt, PERF ? 32'hFFFF_FFFF : 32'd0);
        compare("flush_cnt saturated", flushCnt, PERF ? 32'hFFFF_FFFF : 32'd0);

        compare("scoreboard drained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
